// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between fetch and load/store ports
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_rd_data,
  output logic            imem_ready,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wr_data,
  input  logic            dmem_wr_en,
  output logic [XLEN-1:0] dmem_rd_data,
  output logic            dmem_ready,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wr_data,
  output logic            mem_wr_en,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic            mem_ack,
  output logic            bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Abort fires on the TIMEOUT-th ack-less BUSY edge.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wr_data_q, mem_wr_data_d;
  logic            mem_wr_en_q, mem_wr_en_d;
  logic [XLEN-1:0] imem_rd_data_q, imem_rd_data_d;
  logic [XLEN-1:0] dmem_rd_data_q, dmem_rd_data_d;
  logic            imem_ready_q, imem_ready_d;
  logic            dmem_ready_q, dmem_ready_d;
  logic            bus_err_q, bus_err_d;
  logic            grant_dmem;

  assign imem_rd_data = imem_rd_data_q;
  assign imem_ready   = imem_ready_q;
  assign dmem_rd_data = dmem_rd_data_q;
  assign dmem_ready   = dmem_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_wr_en    = mem_wr_en_q;
  assign bus_err      = bus_err_q;

  // On contention the port that did not win last time gets the grant.
  assign grant_dmem = dmem_req && (!imem_req || !last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_d_q       <= 1'b0;
      tmo_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      mem_wr_en_q    <= 1'b0;
      imem_rd_data_q <= '0;
      dmem_rd_data_q <= '0;
      imem_ready_q   <= 1'b0;
      dmem_ready_q   <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_d_q       <= last_d_d;
      tmo_q          <= tmo_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      mem_wr_en_q    <= mem_wr_en_d;
      imem_rd_data_q <= imem_rd_data_d;
      dmem_rd_data_q <= dmem_rd_data_d;
      imem_ready_q   <= imem_ready_d;
      dmem_ready_q   <= dmem_ready_d;
      bus_err_q      <= bus_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d_d       = last_d_q;
    tmo_d          = tmo_q;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    mem_wr_en_d    = mem_wr_en_q;
    imem_rd_data_d = imem_rd_data_q;
    dmem_rd_data_d = dmem_rd_data_q;
    imem_ready_d   = 1'b0;
    dmem_ready_d   = 1'b0;
    bus_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (imem_req || dmem_req) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
          last_d_d  = grant_dmem;
          if (grant_dmem) begin
            state_d       = BUSY_D;
            mem_addr_d    = dmem_addr;
            mem_wr_data_d = dmem_wr_data;
            mem_wr_en_d   = dmem_wr_en;
          end else begin
            state_d       = BUSY_I;
            mem_addr_d    = imem_addr;
            mem_wr_data_d = '0;
            mem_wr_en_d   = 1'b0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = RESP;
          if (state_q == BUSY_I) begin
            imem_ready_d   = 1'b1;
            imem_rd_data_d = mem_rd_data;
          end else begin
            dmem_ready_d = 1'b1;
            if (!mem_wr_en_q) dmem_rd_data_d = mem_rd_data;
          end
        end else if (tmo_q == TMO_LAST) begin
          mem_req_d    = 1'b0;
          mem_wr_en_d  = 1'b0;
          state_d      = RESP;
          bus_err_d    = 1'b1;
          imem_ready_d = (state_q == BUSY_I);
          dmem_ready_d = (state_q == BUSY_D);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req = 1'b0;
  logic [XLEN-1:0] imem_addr = '0;
  logic [XLEN-1:0] imem_rd_data;
  logic            imem_ready;
  logic            dmem_req = 1'b0;
  logic [XLEN-1:0] dmem_addr = '0;
  logic [XLEN-1:0] dmem_wr_data = '0;
  logic            dmem_wr_en = 1'b0;
  logic [XLEN-1:0] dmem_rd_data;
  logic            dmem_ready;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wr_data;
  logic            mem_wr_en;
  logic [XLEN-1:0] mem_rd_data = '0;
  logic            mem_ack = 1'b0;
  logic            bus_err;

  int n_pass = 0;
  int n_chk  = 0;
  logic [XLEN-1:0] last_d_rd;
  int ng;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rd_data(imem_rd_data), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_wr_en(dmem_wr_en), .dmem_rd_data(dmem_rd_data), .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant; returns the number of edges it took.
  task automatic wait_grant(output int n);
    n = 0;
    while (!mem_req && n < 8) begin
      tick();
      n++;
    end
    check("grant_seen", 32'(mem_req), 32'd1);
  endtask

  task automatic grant_chk(input logic [XLEN-1:0] addr, input logic wr,
                           input logic [XLEN-1:0] wdata);
    int n;
    wait_grant(n);
    check("mem_addr", mem_addr, addr);
    check("mem_wr_en", 32'(mem_wr_en), 32'(wr));
    check("mem_wr_data", mem_wr_data, wdata);
  endtask

  // Holds ack low for 'waits' edges (bus must stay stable), then acks once.
  task automatic complete(input int waits, input logic [XLEN-1:0] rdata,
                          input logic is_d, input logic [XLEN-1:0] addr,
                          input logic wr, input logic [XLEN-1:0] wdata);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("busy_req", 32'(mem_req), 32'd1);
      check("busy_addr", mem_addr, addr);
      check("busy_wr", {31'd0, mem_wr_en}, {31'd0, wr});
      check("busy_wdata", mem_wr_data, wdata);
      check("busy_rdy", {30'd0, imem_ready, dmem_ready}, 32'd0);
    end
    mem_ack = 1'b1;
    mem_rd_data = rdata;
    tick();
    mem_ack = 1'b0;
    mem_rd_data = 32'h5A5A_5A5A;
    check("imem_ready", 32'(imem_ready), 32'(!is_d));
    check("dmem_ready", 32'(dmem_ready), 32'(is_d));
    check("done_req", {30'd0, mem_req, mem_wr_en}, 32'd0);
    check("done_err", 32'(bus_err), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_req", {29'd0, mem_req, mem_wr_en, bus_err}, 32'd0);
    check("rst_rdy", {30'd0, imem_ready, dmem_ready}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_irdata", imem_rd_data, 32'd0);
    rst = 1'b1;
    tick();

    // Asynchronous reset while a store is in flight
    dmem_req = 1'b1; dmem_wr_en = 1'b1; dmem_addr = 32'h3000; dmem_wr_data = 32'hCAFE_0001;
    grant_chk(32'h3000, 1'b1, 32'hCAFE_0001);
    #2 rst = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_wr", {31'd0, mem_wr_en}, 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_wdata", mem_wr_data, 32'd0);
    dmem_req = 1'b0; dmem_wr_en = 1'b0; dmem_wr_data = '0;
    tick();
    rst = 1'b1;
    tick();
    check("arst_nordy", {30'd0, imem_ready, dmem_ready}, 32'd0);
    check("arst_idle", {31'd0, mem_req}, 32'd0);

    // Contention after reset: DMEM wins, then IMEM
    imem_req = 1'b1; imem_addr = 32'h404;
    dmem_req = 1'b1; dmem_addr = 32'h1000;
    grant_chk(32'h1000, 1'b0, 32'd0);
    dmem_req = 1'b0;
    complete(0, 32'hDEAD_BEEF, 1'b1, 32'h1000, 1'b0, 32'd0);
    check("d_rdata", dmem_rd_data, 32'hDEAD_BEEF);
    last_d_rd = 32'hDEAD_BEEF;
    grant_chk(32'h404, 1'b0, 32'd0);
    complete(0, 32'h13, 1'b0, 32'h404, 1'b0, 32'd0);
    check("i_rdata", imem_rd_data, 32'h13);
    check("d_rdata_hold", dmem_rd_data, 32'hDEAD_BEEF);

    // Both held: grants alternate D, I, D, I
    dmem_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic ed;
      ed = (j % 2 == 0);
      grant_chk(ed ? 32'h1000 : 32'h404, 1'b0, 32'd0);
      complete(0, 32'hA000_0000 + 32'(j), ed, ed ? 32'h1000 : 32'h404, 1'b0, 32'd0);
      if (ed) begin
        check("alt_drd", dmem_rd_data, 32'hA000_0000 + 32'(j));
        last_d_rd = 32'hA000_0000 + 32'(j);
      end else begin
        check("alt_ird", imem_rd_data, 32'hA000_0000 + 32'(j));
      end
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    tick();
    check("alt_pulse", {30'd0, imem_ready, dmem_ready}, 32'd0);
    tick();

    // Single fetch, zero-wait memory: ready two edges after sampling
    imem_req = 1'b1; imem_addr = 32'h400;
    wait_grant(ng);
    check("fetch_lat", 32'(ng), 32'd1);
    check("fetch_addr", mem_addr, 32'h400);
    complete(0, 32'h0020_8033, 1'b0, 32'h400, 1'b0, 32'd0);
    imem_req = 1'b0;
    check("fetch_data", imem_rd_data, 32'h0020_8033);
    tick();
    check("fetch_pulse", 32'(imem_ready), 32'd0);

    // Store with 3 wait states; requester inputs scrambled mid-transaction
    dmem_req = 1'b1; dmem_wr_en = 1'b1; dmem_addr = 32'h2000; dmem_wr_data = 32'h1234_5678;
    grant_chk(32'h2000, 1'b1, 32'h1234_5678);
    dmem_req = 1'b0; dmem_wr_en = 1'b0; dmem_addr = 32'hFFFF_0000; dmem_wr_data = 32'h0BAD_0BAD;
    complete(3, 32'hFFFF_FFFF, 1'b1, 32'h2000, 1'b1, 32'h1234_5678);
    check("store_rd_hold", dmem_rd_data, last_d_rd);
    tick();

    // Timeout: no ack for TIMEOUT busy edges
    imem_req = 1'b1; imem_addr = 32'h500;
    grant_chk(32'h500, 1'b0, 32'd0);
    imem_req = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      if (!mem_req || imem_ready || bus_err)
        check("tmo_early", {29'd0, mem_req, imem_ready, bus_err}, 32'd4);
    end
    check("tmo_pending", 32'(mem_req), 32'd1);
    tick();
    check("tmo_rdy_err", {29'd0, mem_req, imem_ready, bus_err}, 32'd3);
    check("tmo_rdata", imem_rd_data, 32'h0020_8033);
    check("tmo_dready", 32'(dmem_ready), 32'd0);
    tick();
    check("tmo_pulse", {30'd0, imem_ready, bus_err}, 32'd0);

    // Ack on the very edge the timeout would fire: completes normally
    imem_req = 1'b1; imem_addr = 32'h504;
    grant_chk(32'h504, 1'b0, 32'd0);
    imem_req = 1'b0;
    complete(TIMEOUT - 1, 32'h600D_F00D, 1'b0, 32'h504, 1'b0, 32'd0);
    check("ack15_data", imem_rd_data, 32'h600D_F00D);
    tick();

    // Spurious ack in IDLE is ignored
    mem_ack = 1'b1; mem_rd_data = 32'h0000_0BAD;
    repeat (2) tick();
    check("idle_ack_rdy", {29'd0, imem_ready, dmem_ready, mem_req}, 32'd0);
    check("idle_ack_data", imem_rd_data, 32'h600D_F00D);
    mem_ack = 1'b0;

    // Request dropped during BUSY_I still completes with one pulse
    imem_req = 1'b1; imem_addr = 32'h700;
    grant_chk(32'h700, 1'b0, 32'd0);
    imem_req = 1'b0; imem_addr = '0;
    complete(2, 32'h77, 1'b0, 32'h700, 1'b0, 32'd0);
    check("drop_data", imem_rd_data, 32'h77);
    tick();
    check("drop_pulse", {30'd0, imem_ready, mem_req}, 32'd0);
    tick();
    check("drop_idle", 32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
